// File: rtl/simd_perm_sequencer_pkg.sv
// Shared types for the SIMD permutation command sequencer.
// Holds the beat geometry, the LUT mode enum and the in-flight tag payload.
// Imported by the sequencer top and by its tag FIFO.
package simd_perm_sequencer_pkg;

  localparam int NumLanes       = 8;
  localparam int NumBanks       = 8;
  localparam int XLEN           = 64;
  localparam int NumInOuts      = NumLanes * NumBanks;
  localparam int MaxBeats       = 255;
  localparam int BeatW          = $clog2(MaxBeats + 1);
  // Must be a power of two and cover the permutation unit pipeline depth.
  localparam int MaxOutstanding = 4;

  typedef enum logic [1:0] {
    LUT2  = 2'd0,
    LUT4  = 2'd1,
    LUT8  = 2'd2,
    LUT16 = 2'd3
  } vlut_e;

  // One entry per beat issued to the unit; drop marks the index-load beat,
  // whose result is consumed here and never forwarded.
  typedef struct packed {
    logic drop;
    logic last;
  } perm_tag_t;

endpackage

// File: rtl/simd_perm_sequencer_tag_fifo.sv
// Purpose: in-order tag FIFO tracking beats in flight inside the permutation unit.
// Latency: pop data is the head entry, combinationally visible; push lands next cycle.
// Backpressure: full_o blocks pushes (caller gates), no same-cycle pop bypass when full.
// Ports: clk_i/rst_i, push_i/push_dat_i, pop_i/pop_dat_o, full_o, empty_o.
module perm_tag_fifo
  import simd_perm_sequencer_pkg::*;
#(
  parameter int  Depth = MaxOutstanding,
  parameter type T     = perm_tag_t
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic push_i,
  input  T     push_dat_i,
  input  logic pop_i,
  output T     pop_dat_o,
  output logic full_o,
  output logic empty_o
);

  localparam int AW = $clog2(Depth);

  // One extra pointer bit distinguishes full from empty; Depth is a power
  // of two so the low bits wrap naturally.
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  T            mem [Depth];

  assign empty_o   = (wr_ptr == rd_ptr);
  assign full_o    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_dat_o = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_i && !full_o) wr_ptr <= wr_ptr + 1'b1;
      if (pop_i && !empty_o) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: entries are only read between push and pop.
  always_ff @(posedge clk_i) begin
    if (push_i && !full_o) mem[wr_ptr[AW-1:0]] <= push_dat_i;
  end

endmodule

// File: rtl/simd_perm_sequencer.sv
// Purpose: sequences one LUT command into an index beat plus N data beats for the
//   permutation unit, drops the index result, forwards data results with last, pulses done.
// Latency: issue and result paths combinational; first issue 1 cycle after command accept.
// Backpressure: res_ready_i stalls result pops only; issue stalls when the tag FIFO is full.
// Ports: cmd_* (command in), data_* (operands in), perm_operand_*/perm_sel_idx_o/
//   perm_permute_o/perm_mode_o (issue out), perm_result_* (unit results in),
//   res_* (results out), done_o (command complete pulse).
module simd_perm_sequencer
  import simd_perm_sequencer_pkg::*;
(
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        cmd_valid_i,
  output logic                        cmd_ready_o,
  input  vlut_e                       cmd_mode_i,
  input  logic [BeatW-1:0]            cmd_nbeats_i,
  input  logic                        data_valid_i,
  output logic                        data_ready_o,
  input  logic [NumInOuts*XLEN-1:0]   data_i,
  output logic                        perm_operand_valid_o,
  input  logic                        perm_operand_ready_i,
  output logic                        perm_sel_idx_o,
  output logic                        perm_permute_o,
  output vlut_e                       perm_mode_o,
  output logic [NumInOuts*XLEN-1:0]   perm_operand_o,
  input  logic                        perm_result_valid_i,
  output logic                        perm_result_ready_o,
  input  logic [NumInOuts*XLEN-1:0]   perm_result_i,
  output logic                        res_valid_o,
  input  logic                        res_ready_i,
  output logic [NumInOuts*XLEN-1:0]   res_data_o,
  output logic                        res_last_o,
  output logic                        done_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IDX   = 2'd1,
    PERM  = 2'd2,
    DRAIN = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [BeatW-1:0] beats_left;
  logic             issuing;
  logic             issue_en;
  logic             issue_fire;
  logic             tag_full;
  logic             tag_empty;
  logic             tag_pop;
  perm_tag_t        tag_push;
  perm_tag_t        tag_head;

  assign issuing    = (state_q == IDX) || (state_q == PERM);
  assign issue_en   = issuing && !tag_full;
  assign issue_fire = issue_en && data_valid_i && perm_operand_ready_i;

  assign perm_operand_valid_o = data_valid_i && issue_en;
  assign data_ready_o         = perm_operand_ready_i && issue_en;
  assign perm_operand_o       = data_i;
  assign res_data_o           = perm_result_i;

  assign tag_push.drop = (state_q == IDX);
  assign tag_push.last = (state_q == PERM) && (beats_left == BeatW'(1));

  always_comb begin
    state_d        = state_q;
    cmd_ready_o    = 1'b0;
    perm_sel_idx_o = 1'b0;
    perm_permute_o = 1'b0;
    done_o         = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready_o = 1'b1;
        if (cmd_valid_i) state_d = IDX;
      end
      IDX: begin
        perm_sel_idx_o = 1'b1;
        if (issue_fire) state_d = (beats_left == '0) ? DRAIN : PERM;
      end
      PERM: begin
        perm_permute_o = 1'b1;
        if (issue_fire && beats_left == BeatW'(1)) state_d = DRAIN;
      end
      DRAIN: begin
        if (tag_empty) begin
          done_o  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      beats_left  <= '0;
      perm_mode_o <= LUT2;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && cmd_valid_i) begin
        perm_mode_o <= cmd_mode_i;
        beats_left  <= cmd_nbeats_i;
      end else if (state_q == PERM && issue_fire) begin
        beats_left <= beats_left - 1'b1;
      end
    end
  end

  // Index results are swallowed without waiting on downstream; data results
  // pass straight through with the tag's last flag.
  always_comb begin
    perm_result_ready_o = 1'b0;
    res_valid_o         = 1'b0;
    res_last_o          = 1'b0;
    if (!tag_empty) begin
      if (tag_head.drop) begin
        perm_result_ready_o = 1'b1;
      end else begin
        res_valid_o         = perm_result_valid_i;
        perm_result_ready_o = res_ready_i;
        res_last_o          = tag_head.last;
      end
    end
  end

  assign tag_pop = perm_result_valid_i && perm_result_ready_o;

  perm_tag_fifo #(
    .Depth (MaxOutstanding),
    .T     (perm_tag_t)
  ) u_tag_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_i     (issue_fire),
    .push_dat_i (tag_push),
    .pop_i      (tag_pop),
    .pop_dat_o  (tag_head),
    .full_o     (tag_full),
    .empty_o    (tag_empty)
  );

  // The unit may only return results for beats we issued.
  result_without_tag : assert property (
    @(posedge clk_i) disable iff (rst_i) !(perm_result_valid_i && tag_empty)
  );

endmodule
